// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU control encodings, functional-unit selects,
// shifter sub-ops, the execute-stage state type and the single-cycle ALU function.
package cpu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] FU_ALU   = 2'b00;
    localparam logic [1:0] FU_SHIFT = 2'b01;
    localparam logic [1:0] FU_LUI   = 2'b10;

    localparam logic [3:0] SH_SLL  = 4'b0000;
    localparam logic [3:0] SH_SRL  = 4'b0001;
    localparam logic [3:0] SH_SLLV = 4'b0010;
    localparam logic [3:0] SH_SRLV = 4'b0011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } exec_state_t;

    typedef struct packed {
        logic [31:0] result;
        logic        ovf;
    } alu_out_t;

    // slt uses the subtract sign corrected by subtract overflow, so it is exact
    // even when src1-src2 wraps.
    function automatic alu_out_t alu_compute(input logic [3:0]  op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] sum;
        logic [31:0] diff;
        logic        ovf_add;
        logic        ovf_sub;
        alu_out_t    r;
        sum     = a + b;
        diff    = a - b;
        ovf_add = ~(a[31] ^ b[31]) & (sum[31] ^ a[31]);
        ovf_sub =  (a[31] ^ b[31]) & (diff[31] ^ a[31]);
        r.result = 32'd0;
        r.ovf    = 1'b0;
        case (op)
            ALU_AND: r.result = a & b;
            ALU_OR:  r.result = a | b;
            ALU_ADD: begin
                r.result = sum;
                r.ovf    = ovf_add;
            end
            ALU_SUB: begin
                r.result = diff;
                r.ovf    = ovf_sub;
            end
            ALU_NOR: r.result = ~(a | b);
            ALU_SLT: r.result = {31'd0, diff[31] ^ ovf_sub};
            default: begin
                r.result = 32'd0;
                r.ovf    = 1'b0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/serial_shifter.sv
// One-bit-per-cycle zero-fill shifter with a 5-bit down-counter; runs while the
// counter is non-zero and exposes the next shifted value plus a last-step flag.
module serial_shifter
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [4:0]        count_i,
    input  logic              dir_right_i,
    output logic [DATA_W-1:0] step_o,
    output logic              last_o
);

    logic [DATA_W-1:0] data_q;
    logic [4:0]        cnt_q;
    logic              right_q;

    // Value after the next single-bit shift.
    assign step_o = right_q ? {1'b0, data_q[DATA_W-1:1]} : {data_q[DATA_W-2:0], 1'b0};
    assign last_o = (cnt_q == 5'd1);

    // Shift register, counter and direction; load wins over stepping.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            cnt_q   <= 5'd0;
            right_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            cnt_q   <= count_i;
            right_q <= dir_right_i;
        end else if (cnt_q != 5'd0) begin
            data_q  <= step_o;
            cnt_q   <= cnt_q - 5'd1;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Multi-cycle execute stage: single-cycle ALU/lui, serial shifter, registered
// result and flags held under a valid/ready output handshake.
module exec_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        ALU_operation_i,
    input  logic [1:0]        FURslt_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [4:0]        shamt_i,
    input  logic [15:0]       imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              overflow_o
);

    exec_state_t       state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;

    alu_out_t          alu_res_s;
    logic [4:0]        sh_k_s;
    logic              sh_right_s;
    logic              sh_load_s;
    logic [DATA_W-1:0] sh_step_s;
    logic              sh_last_s;

    assign alu_res_s = alu_compute(ALU_operation_i, src1_i, src2_i);

    // Shift amount and direction decode; unknown sub-ops degrade to a zero-length shift.
    always_comb begin
        sh_k_s     = 5'd0;
        sh_right_s = 1'b0;
        case (ALU_operation_i)
            SH_SLL:  sh_k_s = shamt_i;
            SH_SRL: begin
                sh_k_s     = shamt_i;
                sh_right_s = 1'b1;
            end
            SH_SLLV: sh_k_s = src1_i[4:0];
            SH_SRLV: begin
                sh_k_s     = src1_i[4:0];
                sh_right_s = 1'b1;
            end
            default: begin
                sh_k_s     = 5'd0;
                sh_right_s = 1'b0;
            end
        endcase
    end

    serial_shifter #(.DATA_W(DATA_W)) u_shifter (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .load_i      (sh_load_s),
        .data_i      (src2_i),
        .count_i     (sh_k_s),
        .dir_right_i (sh_right_s),
        .step_o      (sh_step_s),
        .last_o      (sh_last_s)
    );

    // Next-state and next-result logic; zero flag always follows the final result.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        sh_load_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    state_d = DONE;
                    ovf_d   = 1'b0;
                    case (FURslt_i)
                        FU_ALU: begin
                            result_d = alu_res_s.result;
                            ovf_d    = alu_res_s.ovf;
                        end
                        FU_SHIFT: begin
                            result_d = src2_i;
                            if (sh_k_s != 5'd0) begin
                                sh_load_s = 1'b1;
                                state_d   = SHIFT;
                            end else begin
                                sh_load_s = 1'b0;
                            end
                        end
                        FU_LUI:  result_d = {imm_i, 16'h0000};
                        default: result_d = 32'd0;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (sh_last_s) begin
                    result_d = sh_step_s;
                    state_d  = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        zero_d = (result_d == 32'd0);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= 32'd0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign result_o    = result_q;
    assign zero_o      = zero_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit with hand-computed results, flags and latencies.
module tb_exec_unit;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  ALU_operation_i;
    logic [1:0]  FURslt_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [4:0]  shamt_i;
    logic [15:0] imm_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        overflow_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    exec_unit #(.DATA_W(32)) dut (
        .clk_i           (clk_i),
        .rst_n           (rst_n),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .ALU_operation_i (ALU_operation_i),
        .FURslt_i        (FURslt_i),
        .src1_i          (src1_i),
        .src2_i          (src2_i),
        .shamt_i         (shamt_i),
        .imm_i           (imm_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .result_o        (result_o),
        .zero_o          (zero_o),
        .overflow_o      (overflow_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] fu, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic [15:0] im);
        FURslt_i        = fu;
        ALU_operation_i = op;
        src1_i          = a;
        src2_i          = b;
        shamt_i         = sh;
        imm_i           = im;
    endtask

    // Accept one op, then count cycles until out_valid_o (bounded).
    task automatic run_op(input logic [1:0] fu, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic [15:0] im,
                          output int lat);
        drive(fu, op, a, b, sh, im);
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        drive(2'b00, 4'b0000, 32'd0, 32'd0, 5'd0, 16'd0);
        lat = 1;
        while (!out_valid_o && lat < 64) begin
            @(posedge clk_i); #1;
            lat++;
        end
    endtask

    task automatic take();
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
    endtask

    task automatic op_check(input string tag, input logic [1:0] fu, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                            input logic [15:0] im, input int exp_lat, input logic [31:0] exp_res,
                            input logic exp_zero, input logic exp_ovf);
        int lat;
        run_op(fu, op, a, b, sh, im, lat);
        check({tag, "_lat"},  32'(lat),         32'(exp_lat));
        check({tag, "_res"},  result_o,         exp_res);
        check({tag, "_zero"}, {31'd0, zero_o},  {31'd0, exp_zero});
        check({tag, "_ovf"},  {31'd0, overflow_o}, {31'd0, exp_ovf});
        take();
        check({tag, "_idle"}, {31'd0, in_ready_o}, 32'd1);
    endtask

    initial begin
        int lat;
        rst_n       = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        drive(2'b00, 4'b0000, 32'd0, 32'd0, 5'd0, 16'd0);
        #12;
        check("rst_ready", {31'd0, in_ready_o},  32'd1);
        check("rst_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst_res",   result_o,             32'd0);
        check("rst_zero",  {31'd0, zero_o},      32'd1);
        check("rst_ovf",   {31'd0, overflow_o},  32'd0);
        @(negedge clk_i);
        rst_n = 1'b1;
        @(posedge clk_i); #1;

        op_check("add_ovf", 2'b00, 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 16'd0, 1, 32'h8000_0000, 1'b0, 1'b1);

        // Reset in the middle of a 20-step shift.
        drive(2'b01, 4'b0000, 32'd0, 32'd1, 5'd20, 16'd0);
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        repeat (4) begin
            @(posedge clk_i); #1;
        end
        check("mid_busy", {31'd0, in_ready_o}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_valid", {31'd0, out_valid_o}, 32'd0);
        check("mid_res",   result_o,             32'd0);
        check("mid_zero",  {31'd0, zero_o},      32'd1);
        @(negedge clk_i);
        rst_n = 1'b1;
        @(posedge clk_i); #1;
        check("post_ready", {31'd0, in_ready_o},  32'd1);
        check("post_valid", {31'd0, out_valid_o}, 32'd0);
        op_check("add_post", 2'b00, 4'b0010, 32'd3, 32'd4, 5'd0, 16'd0, 1, 32'd7, 1'b0, 1'b0);

        op_check("sub_zero", 2'b00, 4'b0110, 32'd5, 32'd5, 5'd0, 16'd0, 1, 32'd0, 1'b1, 1'b0);
        op_check("sub_ovf",  2'b00, 4'b0110, 32'h8000_0000, 32'd1, 5'd0, 16'd0, 1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        op_check("and",      2'b00, 4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 16'd0, 1, 32'h0000_F000, 1'b0, 1'b0);
        op_check("or",       2'b00, 4'b0001, 32'h0000_F0F0, 32'h0F00_FF00, 5'd0, 16'd0, 1, 32'h0F00_FFF0, 1'b0, 1'b0);
        op_check("nor",      2'b00, 4'b1100, 32'd0, 32'd0, 5'd0, 16'd0, 1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        op_check("slt_neg",  2'b00, 4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 16'd0, 1, 32'd1, 1'b0, 1'b0);
        op_check("slt_wrap", 2'b00, 4'b0111, 32'h8000_0000, 32'd1, 5'd0, 16'd0, 1, 32'd1, 1'b0, 1'b0);
        op_check("slt_ge",   2'b00, 4'b0111, 32'd1, 32'hFFFF_FFFF, 5'd0, 16'd0, 1, 32'd0, 1'b1, 1'b0);

        op_check("sll31",    2'b01, 4'b0000, 32'd0, 32'd1, 5'd31, 16'd0, 32, 32'h8000_0000, 1'b0, 1'b0);
        op_check("srlv0",    2'b01, 4'b0011, 32'd0, 32'h0000_00F0, 5'd0, 16'd0, 1, 32'h0000_00F0, 1'b0, 1'b0);
        op_check("srl4",     2'b01, 4'b0001, 32'd0, 32'h0000_00F0, 5'd4, 16'd0, 5, 32'h0000_000F, 1'b0, 1'b0);
        op_check("sllv3",    2'b01, 4'b0010, 32'hFFFF_FFE3, 32'h8000_0001, 5'd9, 16'd0, 4, 32'h0000_0008, 1'b0, 1'b0);
        op_check("srl_out",  2'b01, 4'b0001, 32'd0, 32'h0000_0001, 5'd1, 16'd0, 2, 32'd0, 1'b1, 1'b0);
        op_check("sh_bad",   2'b01, 4'b0101, 32'd7, 32'h1234_5678, 5'd7, 16'd0, 1, 32'h1234_5678, 1'b0, 1'b0);

        // lui, then hold the result while an in_valid_i pulse arrives.
        run_op(2'b10, 4'b0000, 32'd0, 32'd0, 5'd0, 16'hABCD, lat);
        check("lui_lat", 32'(lat), 32'd1);
        check("lui_res", result_o, 32'hABCD_0000);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                drive(2'b00, 4'b0010, 32'd1, 32'd1, 5'd0, 16'd0);
                in_valid_i = 1'b1;
            end else begin
                in_valid_i = 1'b0;
            end
            @(posedge clk_i); #1;
            check("hold_res",   result_o,             32'hABCD_0000);
            check("hold_ready", {31'd0, in_ready_o},  32'd0);
            check("hold_valid", {31'd0, out_valid_o}, 32'd1);
        end
        in_valid_i = 1'b0;
        take();
        check("rel_ready", {31'd0, in_ready_o},  32'd1);
        check("rel_valid", {31'd0, out_valid_o}, 32'd0);
        @(posedge clk_i); #1;
        check("rel_quiet", {31'd0, out_valid_o}, 32'd0);
        check("rel_keep",  result_o,             32'hABCD_0000);

        op_check("fu_rsv",  2'b11, 4'b0010, 32'd9, 32'd9, 5'd3, 16'hFFFF, 1, 32'd0, 1'b1, 1'b0);
        op_check("add_pre", 2'b00, 4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd0, 16'd0, 1, 32'h8000_0000, 1'b0, 1'b1);
        op_check("alu_rsv", 2'b00, 4'b0011, 32'h7FFF_FFFF, 32'd1, 5'd0, 16'd0, 1, 32'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
